// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator, prioritised redirects, one-entry pending slot; redirect->pc_o in 1 cycle.
// Advances on !stall_i & pc_ready_i; stalled redirects wait in the slot. Option: PC_GEN_MISALIGN_CHK_EN.
module pc_gen #(
  parameter int                   XLEN        = 32,
  parameter logic [XLEN-1:0]      RESET_VEC   = 32'h0000_0000,
  parameter int                   FETCH_BYTES = 4,
  parameter int                   NUM_REDIR   = 4,
  parameter logic [NUM_REDIR-1:0] OVR_STALL   = 4'b0011
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_addr_i,
  input  logic                      pc_ready_i,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pc_valid_o,
  output logic                      redir_taken_o,
  output logic                      pend_o,
  output logic                      misalign_o,
  output logic [XLEN-1:0]           misalign_addr_o
);

  localparam int LSB = $clog2(FETCH_BYTES);
  localparam int IW  = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_e;

  state_e          state_q;
  logic            pend_q;
  logic [IW-1:0]   pend_idx_q;
  logic [XLEN-1:0] pend_addr_q;

  logic            win_vld_raw;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [XLEN-1:0] win_addr_raw;
  logic [XLEN-1:0] win_addr;
  logic            win_ovr;
  logic            win_bad;

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    win_vld_raw  = 1'b0;
    win_idx      = '0;
    win_addr_raw = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        win_vld_raw  = 1'b1;
        win_idx      = IW'(i);
        win_addr_raw = redir_addr_i[i*XLEN +: XLEN];
      end
    end
    win_ovr = OVR_STALL[win_idx];
  end

`ifdef PC_GEN_MISALIGN_CHK_EN
  // A misaligned winner is rejected outright and the PC behaves as if no channel fired.
  assign win_bad  = win_vld_raw && (win_addr_raw[LSB-1:0] != '0);
  assign win_vld  = win_vld_raw && !win_bad;
  assign win_addr = win_addr_raw;
`else
  assign win_bad  = 1'b0;
  assign win_vld  = win_vld_raw;
  assign win_addr = win_addr_raw & ~XLEN'(FETCH_BYTES - 1);
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

  logic apply_win, apply_pend, capture;

  // A non-override redirect only beats a buffered one of equal or higher priority.
  assign apply_win  = win_vld && (win_ovr || (!stall_i && (!pend_q || win_idx <= pend_idx_q)));
  assign apply_pend = !apply_win && pend_q && !stall_i;
  assign capture    = !apply_win && win_vld && stall_i && !win_ovr &&
                      (!pend_q || win_idx <= pend_idx_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_o          <= RESET_VEC;
      pc_valid_o    <= 1'b0;
      redir_taken_o <= 1'b0;
      pend_o        <= 1'b0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      pend_addr_q   <= '0;
`ifdef PC_GEN_MISALIGN_CHK_EN
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
`endif
    end else begin
      redir_taken_o <= 1'b0;
`ifdef PC_GEN_MISALIGN_CHK_EN
      misalign_o <= 1'b0;
`endif
      if (state_q == BOOT) begin
        state_q    <= RUN;
        pc_valid_o <= 1'b1;
        pc_o       <= RESET_VEC;
      end else begin
`ifdef PC_GEN_MISALIGN_CHK_EN
        if (win_bad) begin
          misalign_o      <= 1'b1;
          misalign_addr_o <= win_addr_raw;
        end
`endif
        if (apply_win || apply_pend) begin
          pc_o          <= apply_win ? win_addr : pend_addr_q;
          redir_taken_o <= 1'b1;
          pend_q        <= 1'b0;
          pend_o        <= 1'b0;
          state_q       <= RUN;
        end else if (capture) begin
          pend_q      <= 1'b1;
          pend_o      <= 1'b1;
          pend_idx_q  <= win_idx;
          pend_addr_q <= win_addr;
          state_q     <= PEND;
        end else if (!stall_i && pc_ready_i) begin
          pc_o <= pc_o + XLEN'(FETCH_BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: each step queues its expected outputs, compared after the edge.
module tb_pc_gen;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         stall_i;
  logic [3:0]   redir_valid_i;
  logic [127:0] redir_addr_i;
  logic         pc_ready_i;
  logic [31:0]  pc_o;
  logic         pc_valid_o;
  logic         redir_taken_o;
  logic         pend_o;
  logic         misalign_o;
  logic [31:0]  misalign_addr_o;

  pc_gen dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .stall_i         (stall_i),
    .redir_valid_i   (redir_valid_i),
    .redir_addr_i    (redir_addr_i),
    .pc_ready_i      (pc_ready_i),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .redir_taken_o   (redir_taken_o),
    .pend_o          (pend_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        pend;
    logic        mis;
    logic [31:0] maddr;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_maddr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int ch, input logic [31:0] a);
    redir_addr_i[ch*32 +: 32] = a;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input string tag, input logic st, input logic rdy, input logic [3:0] v,
                      input logic [31:0] epc, input logic etk, input logic epd, input logic emis);
    exp_t e;
    stall_i       = st;
    pc_ready_i    = rdy;
    redir_valid_i = v;
    e.pc = epc; e.taken = etk; e.pend = epd; e.mis = emis; e.maddr = exp_maddr;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"},    64'(pc_o),            64'(e.pc));
      chk({tag, "_vld"},   64'(pc_valid_o),      64'd1);
      chk({tag, "_taken"}, 64'(redir_taken_o),   64'(e.taken));
      chk({tag, "_pend"},  64'(pend_o),          64'(e.pend));
      chk({tag, "_mis"},   64'(misalign_o),      64'(e.mis));
      chk({tag, "_maddr"}, 64'(misalign_addr_o), 64'(e.maddr));
    end
    @(negedge clk_i);
    redir_valid_i = 4'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    64'(pc_o),            64'h0);
    chk({tag, "_vld"},   64'(pc_valid_o),      64'd0);
    chk({tag, "_taken"}, 64'(redir_taken_o),   64'd0);
    chk({tag, "_pend"},  64'(pend_o),          64'd0);
    chk({tag, "_mis"},   64'(misalign_o),      64'd0);
    chk({tag, "_maddr"}, 64'(misalign_addr_o), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; redir_valid_i = 4'b0; redir_addr_i = '0; pc_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_reset("rst");
    rst_ni = 1'b1;

    // BOOT ignores redirects; then sequential fetch
    set_addr(3, 32'h100);
    step("boot", 0, 1, 4'b1000, 32'h0, 0, 0, 0);
    step("t1a",  0, 1, 4'b0000, 32'h4, 0, 0, 0);
    step("t1b",  0, 1, 4'b0000, 32'h8, 0, 0, 0);
    step("t1c",  0, 1, 4'b0000, 32'hC, 0, 0, 0);
    step("noready", 0, 0, 4'b0000, 32'hC, 0, 0, 0);
    step("stallhold", 1, 1, 4'b0000, 32'hC, 0, 0, 0);

    // wrap
    set_addr(3, 32'hFFFF_FFFC);
    step("t2jmp",  0, 1, 4'b1000, 32'hFFFF_FFFC, 1, 0, 0);
    step("t2wrap", 0, 1, 4'b0000, 32'h0, 0, 0, 0);
    step("t2next", 0, 1, 4'b0000, 32'h4, 0, 0, 0);

    // pending capture and drain regardless of ready
    set_addr(3, 32'h100);
    step("t3cap",   1, 1, 4'b1000, 32'h4,   0, 1, 0);
    step("t3hold",  1, 1, 4'b0000, 32'h4,   0, 1, 0);
    step("t3drain", 0, 0, 4'b0000, 32'h100, 1, 0, 0);
    step("t3adv",   0, 1, 4'b0000, 32'h104, 0, 0, 0);

    // override redirect under stall clears pending
    step("t4cap", 1, 1, 4'b1000, 32'h104, 0, 1, 0);
    set_addr(0, 32'h800);
    step("t4ovr",  1, 1, 4'b0001, 32'h800, 1, 0, 0);
    step("t4hold", 1, 1, 4'b0000, 32'h800, 0, 0, 0);
    step("t4adv",  0, 1, 4'b0000, 32'h804, 0, 0, 0);

    // priority, lower-priority drop, equal/higher replace
    set_addr(1, 32'h200); set_addr(2, 32'h300);
    step("t5prio", 0, 1, 4'b0110, 32'h200, 1, 0, 0);
    step("t5cap2", 1, 1, 4'b0100, 32'h200, 0, 1, 0);
    set_addr(3, 32'h400);
    step("t5drop3", 1, 1, 4'b1000, 32'h200, 0, 1, 0);
    step("t5drain", 0, 1, 4'b0000, 32'h300, 1, 0, 0);
    set_addr(3, 32'h500);
    step("repl_cap3", 1, 1, 4'b1000, 32'h300, 0, 1, 0);
    set_addr(2, 32'h600);
    step("repl_cap2", 1, 1, 4'b0100, 32'h300, 0, 1, 0);
    step("repl_drain", 0, 1, 4'b0000, 32'h600, 1, 0, 0);

    // lower-priority redirect loses to pending; higher one clears it
    set_addr(2, 32'h700);
    step("pw_cap2", 1, 1, 4'b0100, 32'h600, 0, 1, 0);
    set_addr(3, 32'h900);
    step("pw_pend", 0, 1, 4'b1000, 32'h700, 1, 0, 0);
    set_addr(3, 32'h980);
    step("hw_cap3", 1, 1, 4'b1000, 32'h700, 0, 1, 0);
    set_addr(2, 32'hB00);
    step("hw_win2", 0, 1, 4'b0100, 32'hB00, 1, 0, 0);
    step("hw_adv",  0, 1, 4'b0000, 32'hB04, 0, 0, 0);

    // ovr channel under stall with empty slot; redirect with ready low
    set_addr(1, 32'hA00);
    step("ovr1", 1, 1, 4'b0010, 32'hA00, 1, 0, 0);
    set_addr(2, 32'h40);
    step("noready_redir", 0, 0, 4'b0100, 32'h40, 1, 0, 0);

    // misaligned target
    set_addr(3, 32'h102);
`ifdef PC_GEN_MISALIGN_CHK_EN
    exp_maddr = 32'h102;
    step("t6mis",  0, 1, 4'b1000, 32'h44, 0, 0, 1);
    step("t6held", 0, 1, 4'b0000, 32'h48, 0, 0, 0);
`else
    step("t6mask", 0, 1, 4'b1000, 32'h100, 1, 0, 0);
    step("t6adv",  0, 1, 4'b0000, 32'h104, 0, 0, 0);
`endif

    // reset mid-operation with pending occupied
    set_addr(3, 32'h200);
    step("mr_cap", 1, 1, 4'b1000, pc_o, 0, 1, 0);
    rst_ni = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1; stall_i = 1'b0;
    exp_maddr = 32'h0;
    step("rboot", 0, 1, 4'b0000, 32'h0, 0, 0, 0);
    step("radv",  0, 1, 4'b0000, 32'h4, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
